hamming_codec_stream: RTL and testbench
=======================================

Name: hamming_codec_stream

Overview:
- Parametrised, pipelined Hamming encoder/decoder. Successor to the combinational Hamming(7,4) tile.
- Accepts one word per cycle on a valid/ready stream. A per-word mode bit selects encode or decode.
- Decode corrects single-bit errors and reports syndrome and flags. Saturating error counters track link quality.
- Sits behind the tile I/O wrapper; the next tile revision muxes its narrow pins onto this stream.

Parameters:
- DATA_W, 4, data bits per word. Legal values 4, 11, 26 (perfect codes only); any other value is an elaboration error.
- CNT_W, 8, width of each error counter.
- PAR_W, derived (3/4/5), Hamming parity bits. Localparam from package function; not overridable.
- CODE_W, derived, DATA_W+PAR_W, plus 1 when HAMMING_SECDED_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mode  in  1  0=encode, 1=decode; sampled with in_data on acceptance.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept.
- in_data  in  CODE_W  encode: low DATA_W bits used, rest ignored; decode: received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  CODE_W  encode: codeword; decode: corrected data in low DATA_W bits, upper bits 0.
- out_syndrome  out  PAR_W  decode syndrome (0 in encode).
- out_corrected  out  1  decode: single error corrected.
- out_uncorrectable  out  1  decode: double error detected (SECDED only).
- clr_cnt  in  1  synchronous counter clear.
- corr_cnt  out  CNT_W  saturating count of corrected words.
- uncorr_cnt  out  CNT_W  saturating count of uncorrectable words.

Behaviour:
- Reset values: in_ready=1; out_valid=0; out_data, out_syndrome, flags and counters all 0. Reset mid-stream drops in-flight words.
- Bit layout: codeword bit k holds Hamming position k+1. Parity bits sit at power-of-two positions. Data bit 0 upward fills the remaining positions in ascending order. The SECDED overall parity bit is bit CODE_W-1 and covers all other bits (even parity).
- Pipeline: two stages, S1 and S2.
  - S1 registers the word and mode, and computes syndrome/parity.
  - S2 (output register) applies correction and flags.
- Latency: acceptance in cycle N gives out_valid in cycle N+2 when there is no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - A transfer occurs when valid&&ready.
  - adv = !out_valid || out_ready.
  - in_ready = !s1_valid || adv. in_ready depends combinationally on out_ready; this is allowed.
  - Under backpressure the block holds exactly 2 words; no loss, no duplication, order preserved.
  - Outputs are stable while out_valid && !out_ready.
- Decode outcomes, with s = syndrome and p = overall parity (SECDED):
  - s=0, p=0: clean, no flags.
  - s≠0, p=1: flip position s, corrected=1.
  - s=0, p=1: parity bit error; data unchanged, corrected=1.
  - s≠0, p=0: uncorrectable=1, data passed uncorrected.
- Encode outcome: flags 0, syndrome 0.
- Counters:
  - Increment on an output transfer whose corrected/uncorrectable flag is set. Saturate at all-ones.
  - clr_cnt zeroes both counters; clear beats a same-cycle increment (result 0).

Optional Feature:
- Macro HAMMING_SECDED_EN.
- Defined: CODE_W gains the overall parity bit, and double-error detection runs as described above.
- Undefined: plain SEC. Any s≠0 corrects position s. out_uncorrectable is tied 0 and uncorr_cnt is tied 0.

Decomposition:
- Package hamming_pkg holds:
  - function par_w(data_w);
  - mode constants MODE_ENC=0, MODE_DEC=1;
  - function is_pow2(pos) for position mapping.
- Sub-module hamming_syndrome: combinational. Takes a position-mapped word and returns parity vector and overall parity. Shared by encode (parity insertion) and decode (syndrome).

Test Plan (DATA_W=4, SECDED on unless stated):
- Encode 4'hB -> out_data 8'h55 two cycles after acceptance, flags 0.
- Decode 8'h55 -> data 4'hB, syndrome 0, no flags. Decode 8'h51 -> data 4'hB, syndrome 3, corrected=1, corr_cnt=1.
- Decode 8'h56 (double error) -> syndrome 3, uncorrectable=1, uncorr_cnt=1. Decode 8'hD5 -> data 4'hB, syndrome 0, corrected=1.
- Backpressure: stream 3 words with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; all 3 delivered in order once out_ready=1.
- CNT_W=2: 5 corrected words -> corr_cnt=3. clr_cnt asserted in the same cycle as a correction transfer -> 0.
- Assert reset with 2 words in flight -> out_valid=0 and counters 0 immediately; next encode of 4'hB yields 8'h55. Macro undefined: decode 7'h51 -> 4'hB, corrected=1.

Source files
------------

// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the streaming Hamming codec:
//   MODE_ENC / MODE_DEC : per-word mode encodings carried on the 'mode' input
//   par_w(data_w)       : number of Hamming parity bits for a perfect code
//   is_pow2(pos)        : true when a Hamming position holds a parity bit
// -----------------------------------------------------------------------------
package hamming_pkg;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   // Smallest p with 2**p - p - 1 >= data_w. This is exact for the perfect
   // code sizes (4 -> 3, 11 -> 4, 26 -> 5).
   function automatic int par_w(input int data_w);
      int p;
      p = 0;
      for (int i = 1; i <= 8; i++) begin
         if (p == 0 && ((1 << i) - i - 1) >= data_w) p = i;
      end
      return p;
   endfunction

   // Hamming positions are 1-based; parity bits sit at the powers of two.
   function automatic logic is_pow2(input int pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// -----------------------------------------------------------------------------
// hamming_syndrome
// Combinational parity tree over a position-mapped word (bit k = position k+1).
//   word    : HAM_W-bit position-mapped word
//   par     : par[j] = XOR of every bit whose position has bit j set
//   overall : XOR of every bit of word
// With parity slots forced to zero, par is the parity to insert (encode);
// on a received codeword, par is the syndrome (decode).
// -----------------------------------------------------------------------------
module hamming_syndrome
   import hamming_pkg::*;
#(
   parameter  int PAR_W = 3,
   localparam int HAM_W = (1 << PAR_W) - 1
) (
   input  logic [HAM_W-1:0] word,
   output logic [PAR_W-1:0] par,
   output logic             overall
);

   always_comb begin
      par = '0;
      for (int k = 0; k < HAM_W; k++) begin
         for (int j = 0; j < PAR_W; j++) begin
            if ((((k + 1) >> j) % 2) == 1) par[j] = par[j] ^ word[k];
         end
      end
   end

   assign overall = ^word;

endmodule

// File: rtl/hamming_codec_stream.sv
// -----------------------------------------------------------------------------
// hamming_codec_stream
// Two-stage pipelined Hamming encoder/decoder on a valid/ready stream.
// Optional macro HAMMING_SECDED_EN adds an overall parity bit (bit CODE_W-1)
// and double-error detection; without it the block is plain SEC.
//
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   mode                : 0 = encode, 1 = decode, sampled with in_data
//   in_valid/in_ready   : input handshake
//   in_data             : encode: low DATA_W bits; decode: received codeword
//   out_valid/out_ready : output handshake
//   out_data            : encode: codeword; decode: corrected data (low bits)
//   out_syndrome        : decode syndrome, 0 for encode
//   out_corrected       : decode corrected a single error
//   out_uncorrectable   : decode saw a double error (SECDED only)
//   clr_cnt             : synchronous clear of both counters
//   corr_cnt/uncorr_cnt : saturating counts of flagged output transfers
// -----------------------------------------------------------------------------
module hamming_codec_stream
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int CNT_W  = 8,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int HAM_W  = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
   localparam int CODE_W = HAM_W + 1
`else
   localparam int CODE_W = HAM_W
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_data,
   output logic [PAR_W-1:0]  out_syndrome,
   output logic              out_corrected,
   output logic              out_uncorrectable,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   if (DATA_W != 4 && DATA_W != 11 && DATA_W != 26) begin : g_bad_data_w
      $error("hamming_codec_stream: DATA_W must be 4, 11 or 26");
   end

   // Spread data bits over the non-power-of-two positions, parity slots zero.
   function automatic logic [HAM_W-1:0] place_data(input logic [DATA_W-1:0] d);
      logic [HAM_W-1:0] w;
      int               n;
      w = '0;
      n = 0;
      for (int k = 0; k < HAM_W; k++) begin
         if (!is_pow2(k + 1)) begin
            w[k] = d[n];
            n++;
         end
      end
      return w;
   endfunction

   // Inverse of place_data: gather the data positions back in ascending order.
   function automatic logic [DATA_W-1:0] extract_data(input logic [HAM_W-1:0] w);
      logic [DATA_W-1:0] d;
      int                n;
      d = '0;
      n = 0;
      for (int k = 0; k < HAM_W; k++) begin
         if (!is_pow2(k + 1)) begin
            d[n] = w[k];
            n++;
         end
      end
      return d;
   endfunction

   // One-hot mask for position s; s = 0 gives no flip.
   function automatic logic [HAM_W-1:0] flip_mask(input logic [PAR_W-1:0] s);
      logic [HAM_W-1:0] m;
      m = '0;
      for (int k = 0; k < HAM_W; k++) begin
         if (s == PAR_W'(k + 1)) m[k] = 1'b1;
      end
      return m;
   endfunction

   logic              adv;
   logic [CODE_W-1:0] in_word;
   logic              vld_p1;
   logic              mode_p1;
   logic [CODE_W-1:0] word_p1;
   logic [PAR_W-1:0]  syn_p1;
   logic              ovr_p1;
   logic              vld_p2;
   logic [CODE_W-1:0] data_p2;
   logic [PAR_W-1:0]  syn_p2;
   logic              corr_p2;
   logic [CODE_W-1:0] nxt_data;
   logic [PAR_W-1:0]  nxt_syn;
   logic              nxt_corr;
   logic [HAM_W-1:0]  enc_word;
   logic [HAM_W-1:0]  flip;
   logic              xfer;

   assign adv      = !vld_p2 || out_ready;
   assign in_ready = !vld_p1 || adv;
   assign xfer     = vld_p2 && out_ready;

   // Encode words enter S1 already position-mapped with empty parity slots,
   // so the single parity tree yields parity (encode) or syndrome (decode).
   always_comb begin
      if (mode == MODE_ENC) in_word = CODE_W'(place_data(in_data[DATA_W-1:0]));
      else                  in_word = in_data;
   end

   // ---- S1: register word and mode --------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         mode_p1 <= MODE_ENC;
         word_p1 <= '0;
      end else if (in_ready) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            mode_p1 <= mode;
            word_p1 <= in_word;
         end
      end
   end

   hamming_syndrome #(
      .PAR_W   (PAR_W)
   ) u_syndrome (
      .word    (word_p1[HAM_W-1:0]),
      .par     (syn_p1),
      .overall (ovr_p1)
   );

`ifdef HAMMING_SECDED_EN
   logic nxt_unc;
   logic par_err;
`else
   logic unused_ovr;
   assign unused_ovr = ovr_p1;
`endif

   always_comb begin
      nxt_data = '0;
      nxt_syn  = '0;
      nxt_corr = 1'b0;
      enc_word = word_p1[HAM_W-1:0];
      flip     = '0;
`ifdef HAMMING_SECDED_EN
      nxt_unc  = 1'b0;
      par_err  = 1'b0;
`endif
      if (mode_p1 == MODE_ENC) begin
         for (int j = 0; j < PAR_W; j++) enc_word[(1 << j) - 1] = syn_p1[j];
         nxt_data[HAM_W-1:0] = enc_word;
`ifdef HAMMING_SECDED_EN
         // Data bits' XOR plus inserted parity bits' XOR gives even parity.
         nxt_data[CODE_W-1] = ovr_p1 ^ (^syn_p1);
`endif
      end else begin
         nxt_syn = syn_p1;
`ifdef HAMMING_SECDED_EN
         par_err = ovr_p1 ^ word_p1[CODE_W-1];
         if (par_err) begin
            // Odd overall parity: single error, possibly in the parity bit itself.
            nxt_corr = 1'b1;
            flip     = flip_mask(syn_p1);
         end else if (syn_p1 != '0) begin
            nxt_unc = 1'b1;
         end
`else
         if (syn_p1 != '0) begin
            nxt_corr = 1'b1;
            flip     = flip_mask(syn_p1);
         end
`endif
         nxt_data[DATA_W-1:0] = extract_data(word_p1[HAM_W-1:0] ^ flip);
      end
   end

   // ---- S2: output register with correction and flags -------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p2  <= 1'b0;
         data_p2 <= '0;
         syn_p2  <= '0;
         corr_p2 <= 1'b0;
      end else if (adv) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            data_p2 <= nxt_data;
            syn_p2  <= nxt_syn;
            corr_p2 <= nxt_corr;
         end
      end
   end

   assign out_valid     = vld_p2;
   assign out_data      = data_p2;
   assign out_syndrome  = syn_p2;
   assign out_corrected = corr_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         corr_cnt <= '0;
      end else if (clr_cnt) begin
         corr_cnt <= '0;
      end else if (xfer && corr_p2 && (corr_cnt != '1)) begin
         corr_cnt <= corr_cnt + 1'b1;
      end
   end

`ifdef HAMMING_SECDED_EN
   logic unc_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         unc_p2 <= 1'b0;
      end else if (adv && vld_p1) begin
         unc_p2 <= nxt_unc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uncorr_cnt <= '0;
      end else if (clr_cnt) begin
         uncorr_cnt <= '0;
      end else if (xfer && unc_p2 && (uncorr_cnt != '1)) begin
         uncorr_cnt <= uncorr_cnt + 1'b1;
      end
   end

   assign out_uncorrectable = unc_p2;
`else
   assign out_uncorrectable = 1'b0;
   assign uncorr_cnt        = '0;
`endif

endmodule

// File: tb/tb_hamming_codec_stream.sv
// -----------------------------------------------------------------------------
// tb_hamming_codec_stream
// Self-checking bench for hamming_codec_stream with DATA_W=4, CNT_W=2.
// Works with HAMMING_SECDED_EN defined or undefined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hamming_codec_stream;
   import hamming_pkg::*;

   localparam int DATA_W = 4;
   localparam int CNT_W  = 2;
   localparam int PAR_W  = 3;
`ifdef HAMMING_SECDED_EN
   localparam int CODE_W = 8;
`else
   localparam int CODE_W = 7;
`endif

   logic              clk;
   logic              reset;
   logic              mode;
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W-1:0] out_data;
   logic [PAR_W-1:0]  out_syndrome;
   logic              out_corrected;
   logic              out_uncorrectable;
   logic              clr_cnt;
   logic [CNT_W-1:0]  corr_cnt;
   logic [CNT_W-1:0]  uncorr_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   hamming_codec_stream #(
      .DATA_W            (DATA_W),
      .CNT_W             (CNT_W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .mode              (mode),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_syndrome      (out_syndrome),
      .out_corrected     (out_corrected),
      .out_uncorrectable (out_uncorrectable),
      .clr_cnt           (clr_cnt),
      .corr_cnt          (corr_cnt),
      .uncorr_cnt        (uncorr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] syn;
      logic       corr;
      logic       unc;
   } res_t;

   // ---------------- reference model ----------------
   // Hamming position of data bit i for the 4-bit code.
   function automatic int dpos(input int i);
      case (i)
         0:       return 3;
         1:       return 5;
         2:       return 6;
         default: return 7;
      endcase
   endfunction

   // A valid codeword has XOR of all set positions equal to zero, so the
   // parity bits are the binary digits of the XOR of the data positions.
   function automatic logic [7:0] m_encode(input logic [3:0] d);
      logic [7:0] c;
      int         x;
      c = '0;
      x = 0;
      for (int i = 0; i < 4; i++) begin
         if (d[i]) begin
            c[dpos(i) - 1] = 1'b1;
            x = x ^ dpos(i);
         end
      end
      c[0] = x[0];
      c[1] = x[1];
      c[3] = x[2];
`ifdef HAMMING_SECDED_EN
      c[7] = ^c[6:0];
`endif
      return c;
   endfunction

   function automatic res_t m_decode(input logic [7:0] c);
      res_t       r;
      int         s;
      logic [7:0] f;
`ifdef HAMMING_SECDED_EN
      logic       p;
`endif
      r = '0;
      s = 0;
      for (int k = 0; k < 7; k++) if (c[k]) s = s ^ (k + 1);
      f = c;
      r.syn = 3'(s);
`ifdef HAMMING_SECDED_EN
      p = ^c;
      if (p) begin
         r.corr = 1'b1;
         if (s != 0) f[s - 1] = ~f[s - 1];
      end else if (s != 0) begin
         r.unc = 1'b1;
      end
`else
      if (s != 0) begin
         r.corr = 1'b1;
         f[s - 1] = ~f[s - 1];
      end
`endif
      for (int i = 0; i < 4; i++) r.data[i] = f[dpos(i) - 1];
      return r;
   endfunction

   function automatic res_t m_ref(input logic md, input logic [7:0] w);
      res_t r;
      if (md == MODE_DEC) begin
         r = m_decode(w);
      end else begin
         r      = '0;
         r.data = m_encode(w[3:0]);
      end
      return r;
   endfunction

   function automatic int sat(input int n);
      return (n > 3) ? 3 : n;
   endfunction

   function automatic res_t cur_res();
      res_t r;
      r.data = 8'(out_data);
      r.syn  = out_syndrome;
      r.corr = out_corrected;
      r.unc  = out_uncorrectable;
      return r;
   endfunction

   // ---------------- stream driver / collector ----------------
   logic [7:0] st_word[$];
   logic       st_mode[$];
   res_t       got[$];
   int         acc_hold;
   int         stab_err;

   // Drives st_word/st_mode in order and collects every output transfer.
   // out_ready is held low for 'hold' cycles, then high (or random if rnd).
   task automatic stream(input int hold, input bit rnd, input int max_cyc);
      int   sent;
      int   cyc;
      bit   stalled;
      res_t last;
      sent = 0; cyc = 0; stalled = 0; last = '0;
      got.delete(); acc_hold = 0; stab_err = 0;
      while (got.size() < st_word.size() && cyc < max_cyc) begin
         @(negedge clk);
         if (stalled && cur_res() !== last) stab_err++;
         in_valid = (sent < st_word.size());
         if (in_valid) begin
            mode    = st_mode[sent];
            in_data = st_word[sent][CODE_W-1:0];
         end
         out_ready = (cyc >= hold) && (!rnd || $urandom_range(3) != 0);
         #1;
         if (in_valid && in_ready) begin
            sent++;
            if (cyc < hold) acc_hold++;
         end
         if (out_valid && out_ready) got.push_back(cur_res());
         stalled = out_valid && !out_ready;
         last    = cur_res();
         cyc++;
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (out_data !== '0)     begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      n_checks++; if (out_syndrome !== '0) begin n_fail++; $display("FAIL reset_syndrome got=%h exp=0", out_syndrome); end
      n_checks++; if ({out_corrected, out_uncorrectable} !== 2'b00)
         begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", out_corrected, out_uncorrectable); end
      n_checks++; if ({corr_cnt, uncorr_cnt} !== '0)
         begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", corr_cnt, uncorr_cnt); end
      reset = 1'b0;
   endtask

   task automatic test_encode_latency();
      @(negedge clk);
      out_ready = 1'b1;
      mode      = MODE_ENC;
      in_data   = CODE_W'(8'hFB);   // bits above DATA_W are junk and must be ignored
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL enc_latency_early got=%b exp=0", out_valid); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL enc_latency_valid got=%b exp=1", out_valid); end
      n_checks++; if (8'(out_data) !== 8'h55) begin n_fail++; $display("FAIL enc_B_data got=%h exp=55", out_data); end
      n_checks++; if ({out_syndrome, out_corrected, out_uncorrectable} !== 5'd0)
         begin n_fail++; $display("FAIL enc_B_flags got=%h/%b/%b exp=0/0/0", out_syndrome, out_corrected, out_uncorrectable); end
   endtask

   task automatic test_decode_vectors();
      logic [7:0] vec[4];
      res_t       exp;
      int         ec, eu;
      vec[0] = 8'h55; vec[1] = 8'h51; vec[2] = 8'h56; vec[3] = 8'hD5;
      pulse_clr();
      st_word.delete(); st_mode.delete();
      ec = 0; eu = 0;
      for (int i = 0; i < 4; i++) begin
         st_word.push_back(vec[i]); st_mode.push_back(MODE_DEC);
         exp = m_decode(vec[i] & 8'((1 << CODE_W) - 1));
         ec += int'(exp.corr); eu += int'(exp.unc);
      end
      stream(0, 0, 50);
      n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL dec_vec_count got=%0d exp=4", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         exp = m_decode(vec[i] & 8'((1 << CODE_W) - 1));
         n_checks++;
         if (got[i] !== exp) begin
            n_fail++;
            $display("FAIL dec_vec[%0d] in=%h got d=%h s=%0d c=%b u=%b exp d=%h s=%0d c=%b u=%b", i, vec[i],
                     got[i].data, got[i].syn, got[i].corr, got[i].unc, exp.data, exp.syn, exp.corr, exp.unc);
         end
      end
      if (got.size() > 1) begin
         n_checks++;
         if (got[1].data !== 8'h0B || got[1].syn !== 3'd3 || got[1].corr !== 1'b1)
            begin n_fail++; $display("FAIL dec_51 got d=%h s=%0d c=%b exp d=0b s=3 c=1", got[1].data, got[1].syn, got[1].corr); end
      end
      @(negedge clk);
      n_checks++; if (corr_cnt !== CNT_W'(sat(ec)))   begin n_fail++; $display("FAIL dec_vec_corr_cnt got=%0d exp=%0d", corr_cnt, sat(ec)); end
      n_checks++; if (uncorr_cnt !== CNT_W'(sat(eu))) begin n_fail++; $display("FAIL dec_vec_uncorr_cnt got=%0d exp=%0d", uncorr_cnt, sat(eu)); end
   endtask

   task automatic test_back_to_back();
      res_t       exp[$];
      logic [7:0] w;
      logic       md;
      int         ec, eu;
      pulse_clr();
      st_word.delete(); st_mode.delete();
      ec = 0; eu = 0;
      for (int i = 0; i < 40; i++) begin
         md = 1'($urandom_range(1));
         w  = 8'($urandom);
         if (md == MODE_DEC) begin
            case ($urandom_range(2))
               0:       w = m_encode(w[3:0]);
               1:       w = m_encode(w[3:0]) ^ (8'h01 << $urandom_range(CODE_W - 1));
               default: ;
            endcase
            w = w & 8'((1 << CODE_W) - 1);
         end
         st_word.push_back(w); st_mode.push_back(md);
         exp.push_back(m_ref(md, w));
         ec += int'(exp[i].corr); eu += int'(exp[i].unc);
      end
      stream(0, 1, 400);
      n_checks++; if (got.size() != 40) begin n_fail++; $display("FAIL rand_count got=%0d exp=40", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== exp[i]) begin
            n_fail++;
            $display("FAIL rand[%0d] mode=%b in=%h got d=%h s=%0d c=%b u=%b exp d=%h s=%0d c=%b u=%b", i, st_mode[i], st_word[i],
                     got[i].data, got[i].syn, got[i].corr, got[i].unc, exp[i].data, exp[i].syn, exp[i].corr, exp[i].unc);
         end
      end
      @(negedge clk);
      n_checks++; if (corr_cnt !== CNT_W'(sat(ec)))   begin n_fail++; $display("FAIL rand_corr_cnt got=%0d exp=%0d", corr_cnt, sat(ec)); end
      n_checks++; if (uncorr_cnt !== CNT_W'(sat(eu))) begin n_fail++; $display("FAIL rand_uncorr_cnt got=%0d exp=%0d", uncorr_cnt, sat(eu)); end
   endtask

   task automatic test_backpressure();
      logic [3:0] d[3];
      d[0] = 4'h3; d[1] = 4'hC; d[2] = 4'h9;
      st_word.delete(); st_mode.delete();
      for (int i = 0; i < 3; i++) begin st_word.push_back({4'h0, d[i]}); st_mode.push_back(MODE_ENC); end
      stream(5, 0, 40);
      n_checks++; if (acc_hold != 2) begin n_fail++; $display("FAIL bp_accepts_while_stalled got=%0d exp=2", acc_hold); end
      n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_output_stable got=%0d changes exp=0", stab_err); end
      n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i].data !== m_encode(d[i])) begin n_fail++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i].data, m_encode(d[i])); end
      end
   endtask

   task automatic test_saturation();
      pulse_clr();
      st_word.delete(); st_mode.delete();
      for (int i = 0; i < 5; i++) begin
         st_word.push_back(m_encode(4'(i + 2)) ^ (8'h01 << i));
         st_mode.push_back(MODE_DEC);
      end
      stream(0, 0, 50);
      @(negedge clk);
      n_checks++; if (corr_cnt !== 2'd3)   begin n_fail++; $display("FAIL sat_corr_cnt got=%0d exp=3", corr_cnt); end
      n_checks++; if (uncorr_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_uncorr_cnt got=%0d exp=0", uncorr_cnt); end
   endtask

   task automatic test_clear_priority();
      int t;
      @(negedge clk);
      out_ready = 1'b0;
      mode      = MODE_DEC;
      in_data   = CODE_W'(8'h51);
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      t = 0;
      while (!out_valid && t < 10) begin @(negedge clk); t++; end
      n_checks++; if (out_valid !== 1'b1 || out_corrected !== 1'b1)
         begin n_fail++; $display("FAIL clr_setup got valid=%b corr=%b exp 1/1", out_valid, out_corrected); end
      n_checks++; if (corr_cnt !== 2'd3) begin n_fail++; $display("FAIL clr_precount got=%0d exp=3", corr_cnt); end
      out_ready = 1'b1;
      clr_cnt   = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      n_checks++; if (corr_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_beats_incr got=%0d exp=0", corr_cnt); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_word_consumed got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_midstream();
      st_word.delete(); st_mode.delete();
      st_word.push_back(8'h51); st_mode.push_back(MODE_DEC);
      stream(0, 0, 20);
      @(negedge clk);
      n_checks++; if (corr_cnt !== 2'd1) begin n_fail++; $display("FAIL rst_mid_precount got=%0d exp=1", corr_cnt); end
      out_ready = 1'b0;
      mode = MODE_ENC; in_data = CODE_W'(8'h07); in_valid = 1'b1;
      @(negedge clk);
      mode = MODE_DEC; in_data = CODE_W'(8'h51);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inflight got=%b exp=1", out_valid); end
      #1 reset = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0)
         begin n_fail++; $display("FAIL rst_mid_counters got=%0d/%0d exp=0/0", corr_cnt, uncorr_cnt); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      reset = 1'b0;
      st_word.delete(); st_mode.delete();
      st_word.push_back(8'h0B); st_mode.push_back(MODE_ENC);
      stream(0, 0, 20);
      n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL rst_mid_post_count got=%0d exp=1", got.size()); end
      if (got.size() > 0) begin
         n_checks++; if (got[0].data !== 8'h55) begin n_fail++; $display("FAIL rst_mid_post_enc got=%h exp=55", got[0].data); end
      end
      repeat (3) @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_ghost got=%b exp=0", out_valid); end
   endtask

   initial begin
      reset     = 1'b1;
      mode      = MODE_ENC;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      test_reset();
      test_encode_latency();
      test_decode_vectors();
      test_back_to_back();
      test_backpressure();
      test_saturation();
      test_clear_priority();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before test sequence completed");
      $fatal(1, "watchdog");
   end

endmodule
